iob_ethoc_init_seq: RTL and testbench
=====================================

// Module: iob_ethoc_init_seq
// PURPOSE
//  Native-bus master directly upstream of iob_ethoc_sim_wrapper: on a start pulse it programs the MAC
//  (loopback, full-duplex, one RX and one TX buffer descriptor, RX/TX enable), then waits for frame
//  reception by polling RX BD 0 and reports done/error plus the final BD word. Replaces CPU/bench bring-up.
// PARAMETERS
//  ADDR_W        12    native address width (must cover 0x604)
//  DATA_W        32    native data width; only 32 supported
//  RDY_TIMEOUT   256   max cycles valid may wait for ready before error
//  POLL_MAX      1024  max RX BD poll reads before error
//  POLL_GAP      16    idle cycles between consecutive poll reads
// PORTS
//  clk_i      in   1         system clock
//  arst_i     in   1         asynchronous reset, active-low
//  start_i    in   1         1-cycle start pulse; ignored while busy_o=1
//  valid_o    out  1         native request valid
//  address_o  out  ADDR_W    native byte address
//  wdata_o    out  DATA_W    write data
//  wstrb_o    out  DATA_W/8  byte strobes; 0 = read
//  rdata_i    in   DATA_W    read data, valid when ready_i=1
//  ready_i    in   1         transaction complete
//  busy_o     out  1         sequence in progress
//  done_o     out  1         1-cycle pulse: frame received (RX BD E bit cleared)
//  error_o    out  1         sticky until next accepted start
//  err_code_o out  2         0 none, 1 ready timeout, 2 poll exhausted
//  rx_bd_o    out  DATA_W    last RX BD word read
//  step_o     out  4         current sequence index (debug)
// BEHAVIOUR
//  Reset: valid_o=0, address_o=0, wdata_o=0, wstrb_o=0, busy_o=0, done_o=0, error_o=0, err_code_o=0,
//   rx_bd_o=0, step_o=0, FSM=IDLE. Reset mid-sequence aborts at once; valid_o drops asynchronously.
//  Handshake: valid_o and address/wdata/wstrb held stable until the edge sampling ready_i=1; valid_o low
//   the following cycle; >=1 idle cycle between requests. ready_i while valid_o=0 is ignored.
//  Write table (wstrb 0xF): 0 MODER 0x000<-0000A080; 1 MODER<-0000A480; 2 0x604<-00000080;
//   3 0x600<-0010C000; 4 MODER<-0000A481; 5 0x404<-00000000; 6 0x400<-0010D000; 7 MODER<-0000A483.
//  FSM: IDLE -start-> WR(step 0) ; WR -ready-> WR_GAP -> WR(step+1), after step 7 -> POLL_RD ;
//   POLL_RD: read 0x600 (wstrb 0); on ready rx_bd_o<=rdata_i; bit15(E)=0 -> DONE else POLL_WAIT ;
//   POLL_WAIT: POLL_GAP cycles -> POLL_RD ; DONE: done_o=1 one cycle -> IDLE ; ERR -> IDLE.
//  Ready timer: reset at each valid_o rise; reaching RDY_TIMEOUT -> ERR, code 1, valid_o dropped.
//  Poll counter: POLL_MAX reads all with E=1 -> ERR, code 2. Counter width $clog2(POLL_MAX+1).
//  busy_o=1 in every state except IDLE. start_i in same cycle as DONE/ERR exit is ignored.
//  Accepted start clears error_o, err_code_o, rx_bd_o.
// CONFIGURATION
//  ETHOC_SEQ_IRQ_EN defined: extra input interrupt_i (1 bit); table gains step 8 INT_MASK 0x008<-0000007F;
//   POLL_RD/POLL_WAIT replaced by IRQ_WAIT: on interrupt_i=1 issue one read of 0x600, capture rx_bd_o, DONE
//   if E=0 else ERR code 2; POLL_MAX bounds IRQ_WAIT in cycles (also code 2).
//  Undefined: no interrupt_i port, polling as above, 8-entry table.
// STRUCTURE
//  Package iob_ethoc_seq_pkg: FSM state enum, register addresses (MODER, INT_MASK, TX/RX BD), table values,
//   E-bit index 15, error codes.
//  Sub-module iob_ethoc_seq_rom: combinational step -> {address, wdata} lookup; FSM/counters in top.
// TESTING
//  1 start, MAC model ready after 2 cycles, BD read returns 0x0000C000 x3 then 0x00004000 -> 8 writes
//    in table order, 4 reads of 0x600, done_o pulse, rx_bd_o=0x00004000, error_o=0.
//  2 ready_i never asserted on step 2 -> error_o=1, err_code_o=1 after 256 cycles, valid_o=0, busy_o=0.
//  3 BD always 0x0000C000, POLL_MAX=4 -> exactly 4 reads, err_code_o=2; next start clears error_o.
//  4 start_i pulsed during step 5 -> ignored, sequence unchanged; arst_i low at step 3 -> all outputs reset,
//    next start restarts at step 0.
//  5 ETHOC_SEQ_IRQ_EN: 9 writes incl. 0x008<-0x7F, no read until interrupt_i=1, then one read
//    returning 0x00004000 -> done_o.
//  6 Protocol checker all runs: address/wdata/wstrb stable while valid_o=1 && !ready_i.

Source files
------------

// File: rtl/iob_ethoc_seq_pkg.sv
// Shared definitions for the Ethernet MAC init sequencer: FSM states,
// register map, programming values, BD status bit and error codes.
package iob_ethoc_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_WR_GAP,
    S_POLL_RD,
    S_POLL_WAIT,
    S_IRQ_WAIT,
    S_DONE,
    S_ERR
  } seq_state_t;

  typedef enum logic [1:0] {
    ERR_NONE        = 2'd0,
    ERR_RDY_TIMEOUT = 2'd1,
    ERR_POLL        = 2'd2
  } err_code_t;

  // MAC register / buffer-descriptor byte addresses
  localparam logic [11:0] MODER_ADDR      = 12'h000;
  localparam logic [11:0] INT_MASK_ADDR   = 12'h008;
  localparam logic [11:0] TX_BD0_ADDR     = 12'h400;
  localparam logic [11:0] TX_BD0_PTR_ADDR = 12'h404;
  localparam logic [11:0] RX_BD0_ADDR     = 12'h600;
  localparam logic [11:0] RX_BD0_PTR_ADDR = 12'h604;

  // Programming values
  localparam logic [31:0] MODER_BASE   = 32'h0000_A080;
  localparam logic [31:0] MODER_LOOP   = 32'h0000_A480;
  localparam logic [31:0] MODER_RXEN   = 32'h0000_A481;
  localparam logic [31:0] MODER_RXTXEN = 32'h0000_A483;
  localparam logic [31:0] RX_PTR_VAL   = 32'h0000_0080;
  localparam logic [31:0] RX_BD_VAL    = 32'h0010_C000;
  localparam logic [31:0] TX_PTR_VAL   = 32'h0000_0000;
  localparam logic [31:0] TX_BD_VAL    = 32'h0010_D000;
  localparam logic [31:0] INT_MASK_VAL = 32'h0000_007F;

  // Empty bit of an RX buffer descriptor: 1 while the MAC still owns it
  localparam int unsigned BD_E_BIT = 15;

endpackage

// File: rtl/iob_ethoc_seq_rom.sv
// Write-table lookup: sequence step -> {address, write data}.
// Step 8 (interrupt mask) is only reached in builds with interrupt wait.
module iob_ethoc_seq_rom
  import iob_ethoc_seq_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic [3:0]        step,
  output logic [ADDR_W-1:0] address,
  output logic [31:0]       wdata
);

  // Pure combinational table decode
  always_comb begin
    address = '0;
    wdata   = '0;
    case (step)
      4'd0: begin address = ADDR_W'(MODER_ADDR);      wdata = MODER_BASE;   end
      4'd1: begin address = ADDR_W'(MODER_ADDR);      wdata = MODER_LOOP;   end
      4'd2: begin address = ADDR_W'(RX_BD0_PTR_ADDR); wdata = RX_PTR_VAL;   end
      4'd3: begin address = ADDR_W'(RX_BD0_ADDR);     wdata = RX_BD_VAL;    end
      4'd4: begin address = ADDR_W'(MODER_ADDR);      wdata = MODER_RXEN;   end
      4'd5: begin address = ADDR_W'(TX_BD0_PTR_ADDR); wdata = TX_PTR_VAL;   end
      4'd6: begin address = ADDR_W'(TX_BD0_ADDR);     wdata = TX_BD_VAL;    end
      4'd7: begin address = ADDR_W'(MODER_ADDR);      wdata = MODER_RXTXEN; end
      4'd8: begin address = ADDR_W'(INT_MASK_ADDR);   wdata = INT_MASK_VAL; end
      default: ;
    endcase
  end

endmodule

// File: rtl/iob_ethoc_init_seq.sv
// Native-bus master that programs the ethoc MAC for loopback and waits for
// one received frame. Optional macro ETHOC_SEQ_IRQ_EN replaces RX BD polling
// with a wait on interrupt_i (adds the interrupt-mask write as step 8).
module iob_ethoc_init_seq
  import iob_ethoc_seq_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 32,
  parameter int RDY_TIMEOUT = 256,
  parameter int POLL_MAX    = 1024,
  parameter int POLL_GAP    = 16
) (
  input  logic                clk_i,
  input  logic                arst_i,
  input  logic                start_i,
`ifdef ETHOC_SEQ_IRQ_EN
  input  logic                interrupt_i,
`endif
  output logic                valid_o,
  output logic [ADDR_W-1:0]   address_o,
  output logic [DATA_W-1:0]   wdata_o,
  output logic [DATA_W/8-1:0] wstrb_o,
  input  logic [DATA_W-1:0]   rdata_i,
  input  logic                ready_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                error_o,
  output logic [1:0]          err_code_o,
  output logic [DATA_W-1:0]   rx_bd_o,
  output logic [3:0]          step_o
);

  localparam int RW = $clog2(RDY_TIMEOUT + 1);
  localparam int WW = $clog2(((POLL_MAX > POLL_GAP) ? POLL_MAX : POLL_GAP) + 1);
`ifdef ETHOC_SEQ_IRQ_EN
  localparam logic [3:0]  LAST_STEP  = 4'd8;
  localparam seq_state_t  FIRST_WAIT = S_IRQ_WAIT;
`else
  localparam int          PW         = $clog2(POLL_MAX + 1);
  localparam logic [3:0]  LAST_STEP  = 4'd7;
  localparam seq_state_t  FIRST_WAIT = S_POLL_RD;
  logic [PW-1:0]          poll_cnt;
  logic                   poll_last;
`endif

  seq_state_t        state, state_nxt;
  err_code_t         err_code, err_nxt;
  logic [3:0]        step;
  logic [RW-1:0]     rdy_cnt;
  logic [WW-1:0]     wait_cnt;
  logic [DATA_W-1:0] rx_bd;
  logic              error;
  logic              req, wr, rdy_last;
  logic [ADDR_W-1:0] rom_addr;
  logic [31:0]       rom_wdata;

  iob_ethoc_seq_rom #(.ADDR_W(ADDR_W)) u_rom (
    .step    (step),
    .address (rom_addr),
    .wdata   (rom_wdata)
  );

  assign rdy_last  = (rdy_cnt == RW'(RDY_TIMEOUT - 1));
`ifndef ETHOC_SEQ_IRQ_EN
  assign poll_last = (poll_cnt == PW'(POLL_MAX - 1));
`endif

  // State register
  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Next-state decode and request qualifiers
  always_comb begin
    state_nxt = state;
    req       = 1'b0;
    wr        = 1'b0;
    err_nxt   = ERR_NONE;
    case (state)
      S_IDLE: if (start_i) state_nxt = S_WR;
      S_WR: begin
        req = 1'b1;
        wr  = 1'b1;
        if (ready_i) state_nxt = S_WR_GAP;
        else if (rdy_last) begin
          state_nxt = S_ERR;
          err_nxt   = ERR_RDY_TIMEOUT;
        end
      end
      S_WR_GAP: state_nxt = (step == LAST_STEP) ? FIRST_WAIT : S_WR;
      S_POLL_RD: begin
        req = 1'b1;
        if (ready_i) begin
          if (!rdata_i[BD_E_BIT]) state_nxt = S_DONE;
`ifdef ETHOC_SEQ_IRQ_EN
          else begin
            state_nxt = S_ERR;
            err_nxt   = ERR_POLL;
          end
`else
          else if (poll_last) begin
            state_nxt = S_ERR;
            err_nxt   = ERR_POLL;
          end else state_nxt = S_POLL_WAIT;
`endif
        end else if (rdy_last) begin
          state_nxt = S_ERR;
          err_nxt   = ERR_RDY_TIMEOUT;
        end
      end
`ifdef ETHOC_SEQ_IRQ_EN
      S_IRQ_WAIT: begin
        if (interrupt_i) state_nxt = S_POLL_RD;
        else if (wait_cnt == WW'(POLL_MAX - 1)) begin
          state_nxt = S_ERR;
          err_nxt   = ERR_POLL;
        end
      end
`else
      S_POLL_WAIT: if (wait_cnt == WW'(POLL_GAP - 1)) state_nxt = S_POLL_RD;
`endif
      S_DONE:  state_nxt = S_IDLE;
      S_ERR:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Request fields are zero outside a request so reset leaves the bus all-zero
  assign valid_o    = req;
  assign wstrb_o    = wr ? '1 : '0;
  assign address_o  = wr ? rom_addr : (req ? ADDR_W'(RX_BD0_ADDR) : '0);
  assign wdata_o    = wr ? DATA_W'(rom_wdata) : '0;
  assign busy_o     = (state != S_IDLE);
  assign done_o     = (state == S_DONE);
  assign error_o    = error;
  assign err_code_o = err_code;
  assign rx_bd_o    = rx_bd;
  assign step_o     = step;

  // Step index, timers, captured BD word and sticky error status
  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      step     <= '0;
      rdy_cnt  <= '0;
      wait_cnt <= '0;
      rx_bd    <= '0;
      error    <= 1'b0;
      err_code <= ERR_NONE;
`ifndef ETHOC_SEQ_IRQ_EN
      poll_cnt <= '0;
`endif
    end else begin
      rdy_cnt  <= (req && !ready_i) ? rdy_cnt + 1'b1 : '0;
      wait_cnt <= ((state == S_POLL_WAIT || state == S_IRQ_WAIT) && state_nxt == state)
                  ? wait_cnt + 1'b1 : '0;
      if (state == S_IDLE && start_i) begin
        step     <= '0;
        rx_bd    <= '0;
        error    <= 1'b0;
        err_code <= ERR_NONE;
`ifndef ETHOC_SEQ_IRQ_EN
        poll_cnt <= '0;
`endif
      end
      if (state == S_WR_GAP && step != LAST_STEP) step <= step + 1'b1;
      if (state == S_POLL_RD && ready_i) begin
        rx_bd <= rdata_i;
`ifndef ETHOC_SEQ_IRQ_EN
        poll_cnt <= poll_cnt + 1'b1;
`endif
      end
      if (state_nxt == S_ERR && state != S_ERR) begin
        error    <= 1'b1;
        err_code <= err_nxt;
      end
    end
  end

endmodule

// File: tb/tb_iob_ethoc_init_seq.sv
// Self-checking bench for iob_ethoc_init_seq: a bus responder with
// programmable latency, a transaction monitor with protocol checks, and a
// table-driven reference model of the expected write/read sequence.
module tb_iob_ethoc_init_seq;

`ifdef ETHOC_SEQ_IRQ_EN
  localparam int PMAX = 200;
  localparam int NWR  = 9;
`else
  localparam int PMAX = 4;
  localparam int NWR  = 8;
`endif
  localparam int TMO = 256;
  localparam int GAP = 5;

  typedef struct packed {
    logic [11:0] a;
    logic [31:0] d;
    logic [3:0]  s;
  } txn_t;

  logic        clk_i = 1'b0;
  logic        arst_i, start_i, ready_i, interrupt_i;
  logic [31:0] rdata_i;
  logic        valid_o, busy_o, done_o, error_o;
  logic [11:0] address_o;
  logic [31:0] wdata_o, rx_bd_o;
  logic [3:0]  wstrb_o, step_o;
  logic [1:0]  err_code_o;

  txn_t        obs_q[$];
  logic [31:0] bd_q[$];
  int          vectors = 0, miscompares = 0;
  int          done_cnt = 0, cur_run = 0, last_run = 0, proto_bad = 0;
  int          lat = 2;
  bit          hang_604 = 1'b0;

  logic [11:0] tbl_a [9] = '{12'h000, 12'h000, 12'h604, 12'h600, 12'h000,
                             12'h404, 12'h400, 12'h000, 12'h008};
  logic [31:0] tbl_d [9] = '{32'h0000A080, 32'h0000A480, 32'h00000080, 32'h0010C000,
                             32'h0000A481, 32'h00000000, 32'h0010D000, 32'h0000A483,
                             32'h0000007F};

  always #5 clk_i = ~clk_i;

  iob_ethoc_init_seq #(
    .ADDR_W      (12),
    .DATA_W      (32),
    .RDY_TIMEOUT (TMO),
    .POLL_MAX    (PMAX),
    .POLL_GAP    (GAP)
  ) dut (
    .clk_i       (clk_i),
    .arst_i      (arst_i),
    .start_i     (start_i),
`ifdef ETHOC_SEQ_IRQ_EN
    .interrupt_i (interrupt_i),
`endif
    .valid_o     (valid_o),
    .address_o   (address_o),
    .wdata_o     (wdata_o),
    .wstrb_o     (wstrb_o),
    .rdata_i     (rdata_i),
    .ready_i     (ready_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .error_o     (error_o),
    .err_code_o  (err_code_o),
    .rx_bd_o     (rx_bd_o),
    .step_o      (step_o)
  );

  // Bus responder: ready after 'lat' cycles; reads pop the BD response queue
  initial begin
    int wc;
    wc = 0;
    ready_i = 1'b0;
    rdata_i = '0;
    forever begin
      @(posedge clk_i);
      #1;
      ready_i = 1'b0;
      if (valid_o && !(hang_604 && address_o == 12'h604)) begin
        if (wc >= lat) begin
          ready_i = 1'b1;
          if (wstrb_o == 4'h0) rdata_i = (bd_q.size() > 0) ? bd_q.pop_front() : 32'h0000C000;
          else                 rdata_i = $urandom;
          wc = 0;
        end else wc++;
      end else wc = 0;
    end
  end

  // Monitor: completed transactions, done pulses, valid run length, protocol
  initial begin
    logic pv, pr;
    txn_t pt;
    pv = 1'b0; pr = 1'b0; pt = '0;
    forever begin
      @(negedge clk_i);
      if (!arst_i) begin
        pv = 1'b0; pr = 1'b0; cur_run = 0;
      end else begin
        if (done_o) done_cnt++;
        if (valid_o) cur_run++;
        else if (cur_run > 0) begin last_run = cur_run; cur_run = 0; end
        if (valid_o && ready_i) obs_q.push_back({address_o, wdata_o, wstrb_o});
        if (pv && !pr && valid_o && ({address_o, wdata_o, wstrb_o} != pt)) proto_bad++;
        if (pv && pr && valid_o) proto_bad++;
        pv = valid_o; pr = ready_i; pt = {address_o, wdata_o, wstrb_o};
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk_i); start_i = 1'b1;
    @(negedge clk_i); start_i = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk_i);
      if (!busy_o) break;
    end
    check({tag, " idle"}, busy_o, 1'b0);
  endtask

  task automatic wait_step(input string tag, input logic [3:0] s);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk_i);
      if (step_o == s && valid_o) break;
    end
    check({tag, " reach step"}, {step_o, valid_o}, {s, 1'b1});
  endtask

  task automatic check_writes(input string tag, input int base);
    for (int i = 0; i < NWR; i++)
      check($sformatf("%s wr%0d", tag, i), obs_q[base+i], {tbl_a[i], tbl_d[i], 4'hF});
  endtask

  // Reference model: BD responses = nbusy words with E=1, then final word (E=0).
  // Reads stop at the first E=0 word or after PMAX reads.
  task automatic run_seq(input string tag, input int nbusy, input logic [31:0] busy_w,
                         input logic [31:0] final_w, input bit mid_start);
    logic [31:0] resp[$];
    int nreads, base, dbase;
    bit ok;
    for (int i = 0; i < nbusy; i++) resp.push_back((busy_w != 0) ? busy_w : ($urandom | 32'h8000));
    resp.push_back(final_w & ~32'h8000);
    nreads = (resp.size() < PMAX) ? resp.size() : PMAX;
    ok     = (nreads == resp.size());
    bd_q   = resp;
    base   = obs_q.size();
    dbase  = done_cnt;
    pulse_start();
    if (mid_start) begin
      wait_step(tag, 4'd5);
      pulse_start();
    end
    wait_idle(tag);
    check({tag, " ntxn"}, obs_q.size() - base, NWR + nreads);
    if (obs_q.size() - base == NWR + nreads) begin
      check_writes(tag, base);
      for (int i = 0; i < nreads; i++)
        check($sformatf("%s rd%0d", tag, i), {obs_q[base+NWR+i].a, obs_q[base+NWR+i].s}, {12'h600, 4'h0});
    end
    check({tag, " done"},  done_cnt - dbase, ok ? 1 : 0);
    check({tag, " error"}, error_o, !ok);
    check({tag, " code"},  err_code_o, ok ? 2'd0 : 2'd2);
    check({tag, " rx_bd"}, rx_bd_o, resp[nreads-1]);
    bd_q.delete();
  endtask

  initial begin
    int base;
    arst_i = 1'b0; start_i = 1'b0; interrupt_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check("rst valid", valid_o, 1'b0);
    check("rst bus",   {address_o, wdata_o, wstrb_o}, '0);
    check("rst stat",  {busy_o, done_o, error_o, err_code_o, step_o}, '0);
    check("rst rx_bd", rx_bd_o, '0);
    arst_i = 1'b1;
    repeat (2) @(negedge clk_i);

`ifdef ETHOC_SEQ_IRQ_EN
    lat  = 1;
    base = obs_q.size();
    pulse_start();
    repeat (80) @(negedge clk_i);
    check("irq no read", obs_q.size() - base, NWR);
    check("irq busy", busy_o, 1'b1);
    if (obs_q.size() - base == NWR) check_writes("irq", base);
    bd_q.push_back(32'h00004000);
    interrupt_i = 1'b1;
    wait_idle("irq");
    interrupt_i = 1'b0;
    check("irq ntxn", obs_q.size() - base, NWR + 1);
    check("irq read", {obs_q[obs_q.size()-1].a, obs_q[obs_q.size()-1].s}, {12'h600, 4'h0});
    check("irq done", done_cnt, 1);
    check("irq rx_bd", rx_bd_o, 32'h00004000);
    check("irq error", error_o, 1'b0);
`else
    // Directed frame receive: three busy polls, then E cleared
    lat = 2;
    run_seq("t1", 3, 32'h0000C000, 32'h00004000, 1'b0);

    // Ready never returned on the RX BD pointer write
    lat = 1; hang_604 = 1'b1;
    base = obs_q.size();
    pulse_start();
    wait_idle("t2");
    hang_604 = 1'b0;
    check("t2 ntxn",  obs_q.size() - base, 2);
    check("t2 error", {error_o, err_code_o}, {1'b1, 2'd1});
    check("t2 valid", valid_o, 1'b0);
    check("t2 wait",  last_run, TMO);

    // Poll exhaustion, then a new start clears the status
    run_seq("t3", 10, 32'h0000C000, 32'h00004000, 1'b0);
    bd_q.push_back(32'h00004000);
    pulse_start();
    check("t3 clear", {error_o, err_code_o, rx_bd_o}, '0);
    wait_idle("t3b");
    check("t3b error", error_o, 1'b0);
    bd_q.delete();

    // Start while busy is ignored
    run_seq("t4a", 1, 32'h0, 32'h12340000, 1'b1);

    // Asynchronous reset mid-sequence, then a clean restart
    pulse_start();
    wait_step("t4b", 4'd3);
    arst_i = 1'b0;
    #1;
    check("t4b valid", valid_o, 1'b0);
    check("t4b bus",   {address_o, wdata_o, wstrb_o}, '0);
    check("t4b stat",  {busy_o, done_o, error_o, err_code_o, step_o, rx_bd_o}, '0);
    @(negedge clk_i);
    arst_i = 1'b1;
    @(negedge clk_i);
    run_seq("t4c", 2, 32'h0, $urandom, 1'b0);

    // Randomized BD responses and bus latency
    for (int n = 0; n < 8; n++) begin
      lat = $urandom_range(0, 3);
      run_seq($sformatf("rnd%0d", n), $urandom_range(0, 6), 32'h0, $urandom, 1'b0);
    end
`endif
    check("protocol", proto_bad, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
